// File: rtl/comps_monitor.sv
// comps_monitor: tracks heartbeats from five computers and reports which are offline.
// Latency: hb edge first captured at clk k -> comps at k+3; silence -> comps[i]=1 TIMEOUT+1 edges after the FSM took the last edge.
// Backpressure: none; inputs are sampled every cycle and outputs are free-running registered status.
module comps_monitor #(
  parameter int TIMEOUT = 1000,
  parameter int CNT_W   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] hb,
  input  logic [4:0] en,
  output logic [4:0] comps,
  output logic       changed
);

  localparam int NCH = 5;
  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LP_CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_OFFLINE = 2'd0,
    ST_PENDING = 2'd1,
    ST_ONLINE  = 2'd2
  } state_t;

  // hb synchronizer chain: s1/s2 resolve metastability, s3 delays for edge detect
  logic [NCH-1:0]   r_s1;
  logic [NCH-1:0]   r_s2;
  logic [NCH-1:0]   r_s3;
  logic [NCH-1:0]   w_edge;

  state_t           r_state     [NCH];
  state_t           w_state_nxt [NCH];
  logic [CNT_W-1:0] r_cnt       [NCH];
  logic [CNT_W-1:0] w_cnt_nxt   [NCH];

  logic [NCH-1:0]   w_comps_nxt;
  logic [NCH-1:0]   r_comps;
  logic             r_changed;

  // A held-high line yields exactly one edge because s3 catches up after one cycle.
  assign w_edge = r_s2 & ~r_s3;

  // Bring the asynchronous heartbeat lines into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_s1 <= hb;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // Per-channel qualification and timeout: two edges to come online, silence drops it.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = r_cnt[i];
      if (!en[i]) begin
        // Disabled channels are parked offline regardless of heartbeat activity.
        w_state_nxt[i] = ST_OFFLINE;
        w_cnt_nxt[i]   = '0;
      end else begin
        case (r_state[i])
          ST_OFFLINE: begin
            w_cnt_nxt[i] = '0;
            if (w_edge[i]) begin
              w_state_nxt[i] = ST_PENDING;
            end
          end
          ST_PENDING, ST_ONLINE: begin
            // An edge arriving on the timeout cycle still counts: edge has priority.
            if (w_edge[i]) begin
              w_state_nxt[i] = ST_ONLINE;
              w_cnt_nxt[i]   = '0;
            end else if (r_cnt[i] == LP_CNT_LAST) begin
              w_state_nxt[i] = ST_OFFLINE;
              w_cnt_nxt[i]   = '0;
            end else begin
              w_cnt_nxt[i]   = r_cnt[i] + LP_CNT_ONE;
            end
          end
          default: begin
            w_state_nxt[i] = ST_OFFLINE;
            w_cnt_nxt[i]   = '0;
          end
        endcase
      end
    end
  end

  // Channel state and timeout counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        r_state[i] <= ST_OFFLINE;
        r_cnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
      end
    end
  end

  // Status vector decoded purely from the state register: 0 = online.
  always_comb begin
    w_comps_nxt = '1;
    for (int i = 0; i < NCH; i++) begin
      w_comps_nxt[i] = (r_state[i] != ST_ONLINE);
    end
  end

  // Register the status and flag any change with a single one-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_comps   <= '1;
      r_changed <= 1'b0;
    end else begin
      r_comps   <= w_comps_nxt;
      r_changed <= (w_comps_nxt != r_comps);
    end
  end

  assign comps   = r_comps;
  assign changed = r_changed;

endmodule

// File: tb/tb_comps_monitor.sv
// tb_comps_monitor: directed heartbeat scenarios checked every cycle against a run-length model.
// Latency: model predicts comps one edge after the recognised state; hb edges are recognised two edges after capture.
// Backpressure: none; stimulus drives hb/en on falling clk edges.
module tb_comps_monitor;

  localparam int T = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] hb;
  logic [4:0] en;
  logic [4:0] comps;
  logic       changed;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  comps_monitor #(.TIMEOUT(T), .CNT_W(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .hb      (hb),
    .en      (en),
    .comps   (comps),
    .changed (changed)
  );

  // ---------------- model ----------------
  // A channel is online when its current run holds at least two recognised edges,
  // where a run ends after T edges without a recognised edge or when disabled.
  logic [4:0] m_d1 = '0, m_d2 = '0, m_d3 = '0;
  int         m_run  [5];
  int         m_last [5];
  int         m_t = 0;
  logic [4:0] m_comps = 5'b11111;
  logic       m_chg = 1'b0;
  logic [4:0] m_seen;
  logic [4:0] m_nxt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_d1 = '0; m_d2 = '0; m_d3 = '0;
      m_t = 0;
      m_comps = 5'b11111;
      m_chg = 1'b0;
      for (int i = 0; i < 5; i++) begin
        m_run[i] = 0;
        m_last[i] = 0;
      end
    end else begin
      m_t = m_t + 1;
      m_seen = m_d2 & ~m_d3;
      for (int i = 0; i < 5; i++) m_nxt[i] = !(m_run[i] >= 2);
      m_chg = (m_nxt != m_comps);
      m_comps = m_nxt;
      for (int i = 0; i < 5; i++) begin
        if (!en[i]) begin
          m_run[i] = 0;
        end else if (m_seen[i]) begin
          m_run[i] = (m_run[i] > 0) ? 2 : 1;
          m_last[i] = m_t;
        end else if (m_run[i] > 0 && (m_t - m_last[i]) >= T) begin
          m_run[i] = 0;
        end
      end
      m_d3 = m_d2; m_d2 = m_d1; m_d1 = hb;
    end
  end

  // ---------------- helpers ----------------
  logic       rec_on = 1'b0;
  logic [4:0] rec [$];
  logic [4:0] build_m   [6]  = '{5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111, 5'b11111};
  logic [4:0] drop_m    [8]  = '{5'b01111, 5'b01111, 5'b00111, 5'b00111,
                                  5'b00011, 5'b00011, 5'b00001, 5'b00001};
  logic [4:0] sweep_exp [10] = '{5'b11110, 5'b11100, 5'b11000, 5'b10000, 5'b00000,
                                  5'b10000, 5'b11000, 5'b11100, 5'b11110, 5'b11111};

  task automatic chk(input string nm, input logic [4:0] act, input logic [4:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // One-cycle pulse captured by the rising edge between the two falling edges.
  task automatic pulse(input logic [4:0] m);
    @(negedge clk); hb = hb | m;
    @(negedge clk); hb = hb & ~m;
  endtask

  // ---------------- stimulus and checking ----------------
  initial begin
    hb = '0;
    en = 5'b11111;
    rst_n = 1'b0;
    fork
      begin : cmp
        forever begin
          @(posedge clk); #1;
          if (rst_n) begin
            chk("model_comps", comps, m_comps);
            chk("model_changed", {4'b0, changed}, {4'b0, m_chg});
            if (rec_on && changed) rec.push_back(comps);
          end
        end
      end
      begin : stim
        repeat (3) @(posedge clk); #1;
        chk("reset_comps", comps, 5'b11111);
        chk("reset_changed", {4'b0, changed}, 5'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (4) @(posedge clk); #1;
        chk("release_comps", comps, 5'b11111);

        // Qualification: two pulses 4 apart, then timeout boundary.
        pulse(5'b00001);
        repeat (3) @(posedge clk); #1;
        chk("qual_first", comps, 5'b11111);
        pulse(5'b00001);
        repeat (3) @(posedge clk); #1;
        chk("qual_second", comps, 5'b11110);
        chk("qual_chg", {4'b0, changed}, 5'd1);
        @(posedge clk); #1;
        chk("qual_chg_once", {4'b0, changed}, 5'd0);
        repeat (6) @(posedge clk); #1;
        chk("timeout_hold", comps, 5'b11110);
        @(posedge clk); #1;
        chk("timeout_fire", comps, 5'b11111);

        // Single glitch, then a stale second pulse 12 later stays pending.
        repeat (4) @(posedge clk);
        pulse(5'b00100);
        repeat (11) @(posedge clk);
        pulse(5'b00100);
        repeat (3) @(posedge clk); #1;
        chk("glitch_stale", comps, 5'b11111);
        repeat (12) @(posedge clk);

        // Channel 1 refreshed every 8 cycles stays online; then silence.
        pulse(5'b00010);
        repeat (4) begin
          repeat (7) @(posedge clk);
          pulse(5'b00010);
        end
        repeat (10) @(posedge clk); #1;
        chk("boundary_hold", comps, 5'b11101);
        @(posedge clk); #1;
        chk("boundary_fire", comps, 5'b11111);
        chk("boundary_chg", {4'b0, changed}, 5'd1);

        // Gap of 9 from a pending edge restarts qualification.
        repeat (4) @(posedge clk);
        pulse(5'b00010);
        repeat (8) @(posedge clk);
        pulse(5'b00010);
        repeat (3) @(posedge clk); #1;
        chk("gap9_pending", comps, 5'b11111);
        pulse(5'b00010);
        repeat (3) @(posedge clk); #1;
        chk("gap9_then_online", comps, 5'b11101);
        repeat (14) @(posedge clk);

        // Sweep all channels online one at a time, then drop in reverse.
        rec_on = 1'b1;
        for (int j = 0; j < 6; j++) begin
          pulse(build_m[j]);
          if (j < 5) repeat (3) @(posedge clk);
        end
        repeat (3) @(posedge clk); #1;
        chk("sweep_full", comps, 5'b00000);
        @(posedge clk);
        for (int j = 0; j < 8; j++) begin
          pulse(drop_m[j]);
          if (j < 7) repeat (4) @(posedge clk);
        end
        repeat (16) @(posedge clk); #1;
        rec_on = 1'b0;
        chk("sweep_pulses", 5'(rec.size()), 5'd10);
        for (int j = 0; j < 10; j++) begin
          if (j < rec.size()) chk("sweep_step", rec[j], sweep_exp[j]);
        end

        // Enable override on channels 3 and 4.
        pulse(5'b11000);
        repeat (2) @(posedge clk);
        pulse(5'b11000);
        repeat (3) @(posedge clk); #1;
        chk("en_pre", comps, 5'b00111);
        pulse(5'b11000);
        en = 5'b00111;
        repeat (2) @(posedge clk); #1;
        chk("en_drop", comps, 5'b11111);
        chk("en_drop_chg", {4'b0, changed}, 5'd1);
        repeat (2) begin
          pulse(5'b11000);
          repeat (2) @(posedge clk);
        end
        repeat (4) @(posedge clk);
        @(negedge clk) en = 5'b11111;
        pulse(5'b11000);
        repeat (3) @(posedge clk); #1;
        chk("en_fresh1", comps, 5'b11111);
        pulse(5'b11000);
        repeat (3) @(posedge clk); #1;
        chk("en_fresh2", comps, 5'b00111);
        repeat (14) @(posedge clk);

        // hb held high gives one edge and does not refresh the timeout.
        pulse(5'b00001);
        repeat (2) @(posedge clk);
        @(negedge clk) hb[0] = 1'b1;
        repeat (4) @(posedge clk); #1;
        chk("hold_online", comps, 5'b11110);
        repeat (8) @(posedge clk); #1;
        chk("hold_expire", comps, 5'b11111);
        @(negedge clk) hb[0] = 1'b0;
        repeat (12) @(posedge clk);

        // Asynchronous reset mid-run discards all progress.
        pulse(5'b11111);
        repeat (2) @(posedge clk);
        pulse(5'b11111);
        repeat (3) @(posedge clk); #1;
        chk("rst_pre", comps, 5'b00000);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_comps", comps, 5'b11111);
        chk("rst_async_chg", {4'b0, changed}, 5'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        pulse(5'b00001);
        repeat (3) @(posedge clk); #1;
        chk("rst_discard", comps, 5'b11111);
        repeat (12) @(posedge clk); #1;
      end
    join_any
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
